// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit6=g ... bit0=a)
// and the decoder handshake state.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      TRACK = 1'b0,
      HOLD  = 1'b1
   } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational classifier: maps an active-low segment pattern to a digit,
// the blank code, or neither (illegal).
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [2:0] value,
   output logic       is_digit,
   output logic       is_blank
);

   // NOTE: every output gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      value    = 3'd0;
      is_digit = 1'b1;
      is_blank = 1'b0;
      case (pattern)
         SEG_0:     value = 3'd0;
         SEG_1:     value = 3'd1;
         SEG_2:     value = 3'd2;
         SEG_3:     value = 3'd3;
         SEG_4:     value = 3'd4;
         SEG_5:     value = 3'd5;
         SEG_6:     value = 3'd6;
         SEG_7:     value = 3'd7;
         SEG_BLANK: begin
            is_digit = 1'b0;
            is_blank = 1'b1;
         end
         default:   is_digit = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_decoder.sv
// Watches an active-low 7-segment bus, accepts each pattern once it has held
// stable, and returns decoded digits over valid/ready with blank/illegal flags.
module seg7_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       leds,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [2:0]       digit,
   output logic             blank,
   output logic             invalid,
   output logic             overrun,
   output logic [ERR_W-1:0] err_count
);

   localparam int unsigned CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [6:0]       s;
   logic [CNT_W-1:0] cnt;
   state_t           state;

   logic [2:0] dec_value;
   logic       dec_digit;
   logic       dec_blank;
   logic       accept;
   logic       digit_accept;

   seg7_pattern_decode u_decode (
      .pattern  (s),
      .value    (dec_value),
      .is_digit (dec_digit),
      .is_blank (dec_blank)
   );

   // One accept per stable period: the edge where cnt reaches saturation.
   assign accept       = (leds == s) && (cnt == CNT_LAST);
   assign digit_accept = accept && dec_digit;

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         s         <= SEG_BLANK;
         cnt       <= CNT_MAX;
         state     <= TRACK;
         out_valid <= 1'b0;
         digit     <= 3'd0;
         blank     <= 1'b0;
         invalid   <= 1'b0;
         overrun   <= 1'b0;
         err_count <= '0;
      end else begin
         blank   <= 1'b0;
         invalid <= 1'b0;

         if (leds != s) begin
            s   <= leds;
            cnt <= '0;
         end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end

         if (accept && dec_blank) begin
            blank <= 1'b1;
         end
         if (accept && !dec_digit && !dec_blank) begin
            invalid <= 1'b1;
            if (err_count != '1) begin
               err_count <= err_count + 1'b1;
            end
         end

         case (state)
            TRACK: begin
               if (digit_accept) begin
                  digit     <= dec_value;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (digit_accept) begin
                  // Handshake on the accept edge frees the slot for the new digit.
                  if (out_ready) begin
                     digit <= dec_value;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= TRACK;
               end
            end
            default: state <= TRACK;
         endcase
      end
   end

endmodule
